// File: rtl/rotator_pkg.sv
// Shared rotation codes and FSM state encoding for the frame-buffered image rotator.
package rotator_pkg;

  localparam logic [1:0] ROT_0   = 2'b00;
  localparam logic [1:0] ROT_90  = 2'b01;
  localparam logic [1:0] ROT_180 = 2'b10;
  localparam logic [1:0] ROT_270 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_e;

endpackage

// File: rtl/frame_ram.sv
// Single-port frame store with a registered read port; one access per cycle.
module frame_ram #(
  parameter int DEPTH = 65536,
  parameter int PIX_W = 8,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it can map onto block RAM; every frame rewrites it fully.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/image_rotator.sv
// Buffers one raster frame, then streams it back rotated by 0/90/180/270 degrees clockwise
// through a synchronous RAM read followed by a 2-entry skid buffer.
module image_rotator
  import rotator_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       rot,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_eof,
  output logic             done,
  output logic             busy
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXD  = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW    = $clog2(MAXD);

  state_e           state_q, state_d;
  logic [1:0]       rot_q;
  logic [AW-1:0]    wr_cnt_q;
  logic [CW-1:0]    orow_q, ocol_q;
  logic             all_issued_q;
  logic             rd_vld_q, rd_eol_q, rd_eof_q;
  logic             done_q;
  logic [PIX_W-1:0] fifo_data_q [2];
  logic [1:0]       fifo_eol_q, fifo_eof_q, fifo_cnt_q;
  logic             fifo_wr_q, fifo_rd_q;

  logic             start_acc, wr_fire, wr_last, pop, issue, col_last, row_last;
  logic [2:0]       occ;
  logic [CW-1:0]    ow_last, oh_last;
  logic [AW-1:0]    r_a, c_a, rd_addr, ram_addr;
  logic [PIX_W-1:0] ram_rdata;

  // start is blocked during the done cycle so a frame cannot restart back-to-back.
  assign start_acc = (state_q == ST_IDLE) && start && !done_q;
  assign wr_fire   = (state_q == ST_LOAD) && in_valid;
  assign wr_last   = wr_fire && (wr_cnt_q == AW'(DEPTH - 1));
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Pixels in flight plus buffered may never exceed the two skid slots.
  assign occ   = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q};
  assign issue = (state_q == ST_READ) && !all_issued_q && (occ < (3'd2 + {2'b00, pop}));

  assign ow_last  = rot_q[0] ? CW'(IMG_H - 1) : CW'(IMG_W - 1);
  assign oh_last  = rot_q[0] ? CW'(IMG_W - 1) : CW'(IMG_H - 1);
  assign col_last = (ocol_q == ow_last);
  assign row_last = (orow_q == oh_last);
  assign r_a      = AW'(orow_q);
  assign c_a      = AW'(ocol_q);

  // NOTE: every variable driven here gets a default first so no latch can be inferred.
  always_comb begin
    rd_addr = '0;
    unique case (rot_q)
      ROT_0:   rd_addr = r_a * AW'(IMG_W) + c_a;
      ROT_90:  rd_addr = (AW'(IMG_H - 1) - c_a) * AW'(IMG_W) + r_a;
      ROT_180: rd_addr = (AW'(IMG_H - 1) - r_a) * AW'(IMG_W) + (AW'(IMG_W - 1) - c_a);
      ROT_270: rd_addr = c_a * AW'(IMG_W) + (AW'(IMG_W - 1) - r_a);
      default: rd_addr = '0;
    endcase
  end

  assign ram_addr = (state_q == ST_LOAD) ? wr_cnt_q : rd_addr;

  frame_ram #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .addr_i  (ram_addr),
    .wdata_i (in_data),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_LOAD;
      ST_LOAD: if (wr_last) state_d = ST_READ;
      ST_READ: if (pop && fifo_eof_q[fifo_rd_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rot_q        <= ROT_0;
      wr_cnt_q     <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      all_issued_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_eol_q     <= 1'b0;
      rd_eof_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= issue;
      rd_eol_q <= col_last;
      rd_eof_q <= col_last && row_last;
      done_q   <= pop && fifo_eof_q[fifo_rd_q];
      if (start_acc) rot_q <= rot;
      if (wr_fire) wr_cnt_q <= wr_last ? '0 : wr_cnt_q + AW'(1);
      if (issue) begin
        ocol_q <= col_last ? '0 : ocol_q + CW'(1);
        if (col_last) orow_q <= row_last ? '0 : orow_q + CW'(1);
        if (col_last && row_last) all_issued_q <= 1'b1;
      end
      if (state_q != ST_READ) all_issued_q <= 1'b0;
    end
  end

  // Skid buffer: pushes from the RAM pipeline stage, pops on the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_eol_q     <= '0;
      fifo_eof_q     <= '0;
      fifo_cnt_q     <= '0;
      fifo_wr_q      <= 1'b0;
      fifo_rd_q      <= 1'b0;
    end else begin
      if (rd_vld_q) begin
        fifo_data_q[fifo_wr_q] <= ram_rdata;
        fifo_eol_q[fifo_wr_q]  <= rd_eol_q;
        fifo_eof_q[fifo_wr_q]  <= rd_eof_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      unique case ({rd_vld_q, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign out_data = fifo_data_q[fifo_rd_q];
  assign out_eol  = out_valid && fifo_eol_q[fifo_rd_q];
  assign out_eof  = out_valid && fifo_eof_q[fifo_rd_q];
  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule
